// File: rtl/mem_io_responder_if.sv
// ============================================================================
// Module  : mem_io_responder_if
// Brief   : Core data bus, BRAM port and UART byte streams of mem_io_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_io_responder_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        req;
  logic [31:0] readdata;
  logic [19:0] bram_addra;
  logic        bram_wea;
  logic [31:0] bram_dina;
  logic [31:0] bram_douta;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  adr, writedata, memwrite, req, bram_douta, tx_ready, rx_data, rx_valid,
    output readdata, bram_addra, bram_wea, bram_dina, tx_data, tx_valid, rx_ready
  );

  modport master (
    output adr, writedata, memwrite, req, bram_douta, tx_ready, rx_data, rx_valid,
    input  readdata, bram_addra, bram_wea, bram_dina, tx_data, tx_valid, rx_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// Module  : mem_io_responder
// Brief   : Data-bus responder splitting accesses between BRAM and a UART MMIO page
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_io_responder #(
  parameter int         TX_DEPTH  = 16,
  parameter int         RX_DEPTH  = 16,
  parameter logic [3:0] IO_NIBBLE = 4'hF
) (
  input  logic              clk,
  input  logic              rstn,
  mem_io_responder_if.slave bus
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  logic       w_io_sel;
  logic [1:0] w_reg;
  logic       w_unused_adr;

  assign w_io_sel     = (bus.adr[31:28] == IO_NIBBLE);
  assign w_reg        = bus.adr[3:2];
  assign w_unused_adr = ^{bus.adr[27:22], bus.adr[1:0]};

  assign bus.bram_addra = bus.adr[21:2];
  assign bus.bram_wea   = bus.memwrite & ~w_io_sel;
  assign bus.bram_dina  = bus.writedata;

  // ---------------- TX FIFO (core -> UART transmitter) ----------------
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wp;
  logic [TX_AW-1:0] r_tx_rp;
  logic [TX_CW-1:0] r_tx_cnt;
  logic             r_ovf;
  logic             w_tx_full, w_tx_empty, w_tx_pop, w_tx_wr, w_tx_push, w_stat_wr;

  assign w_tx_full  = (r_tx_cnt == TX_CW'(TX_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_pop   = ~w_tx_empty & bus.tx_ready;
  assign w_tx_wr    = bus.req & bus.memwrite & w_io_sel & (w_reg == 2'd0);
  // A write into a full FIFO still lands if the transmitter frees a slot this cycle
  assign w_tx_push  = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_stat_wr  = bus.req & bus.memwrite & w_io_sel & (w_reg == 2'd2);

  assign bus.tx_valid = ~w_tx_empty;
  assign bus.tx_data  = r_tx_mem[r_tx_rp];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.writedata[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + TX_CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - TX_CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_stat_wr)                 r_ovf <= 1'b0;
      else if (w_tx_wr & ~w_tx_push) r_ovf <= 1'b1;
    end
  end

  // ---------------- RX FIFO (UART receiver -> core) ----------------
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wp;
  logic [RX_AW-1:0] r_rx_rp;
  logic [RX_CW-1:0] r_rx_cnt;
  logic             w_rx_full, w_rx_empty, w_rx_push, w_rx_rd, w_rx_pop;

  assign w_rx_full  = (r_rx_cnt == RX_CW'(RX_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_push  = bus.rx_valid & ~w_rx_full;
  assign w_rx_rd    = bus.req & ~bus.memwrite & w_io_sel & (w_reg == 2'd1);
  assign w_rx_pop   = w_rx_rd & ~w_rx_empty;

  assign bus.rx_ready = ~w_rx_full;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + RX_CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - RX_CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // ---------------- Read path: one-cycle latency for both regions ----------------
  logic [31:0] w_status;
  logic [31:0] w_io_rdata;
  logic        r_sel;
  logic [31:0] r_io_rdata;

  assign w_status = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), 4'h0,
                     r_ovf, w_tx_empty, ~w_tx_full, ~w_rx_empty};

  always_comb begin
    w_io_rdata = '0;
    case (w_reg)
      2'd1:    if (!w_rx_empty) w_io_rdata = {24'h0, r_rx_mem[r_rx_rp]};
      2'd2:    w_io_rdata = w_status;
      default: w_io_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel      <= 1'b0;
      r_io_rdata <= '0;
    end else begin
      r_sel      <= w_io_sel;
      r_io_rdata <= w_io_rdata;
    end
  end

  assign bus.readdata = r_sel ? r_io_rdata : bus.bram_douta;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// Module  : tb_mem_io_responder
// Brief   : Directed and randomized bench for mem_io_responder against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

  localparam logic [31:0] TXA = 32'hF000_0000;
  localparam logic [31:0] RXA = 32'hF000_0004;
  localparam logic [31:0] STA = 32'hF000_0008;
  localparam logic [31:0] RSV = 32'hF000_000C;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_io_responder_if bus ();

  mem_io_responder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // External block RAM with one-cycle read latency
  logic [31:0] bram [0:1023];
  always @(posedge clk) begin
    if (bus.bram_wea) bram[bus.bram_addra[9:0]] <= bus.bram_dina;
    bus.bram_douta <= bram[bus.bram_addra[9:0]];
  end

  // Reference model: byte queues for the two FIFOs plus the sticky overflow flag
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic        ovf;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rd;

  function automatic logic [31:0] model_status();
    return {8'h00, 8'(txq.size()), 8'(rxq.size()), 4'h0, ovf,
            (txq.size() == 0), (txq.size() < DEPTH), (rxq.size() > 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One bus cycle: drive at negedge, predict, sample just after the rising edge
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic rq, input logic txr, input logic rxv,
                       input logic [7:0] rxd, output logic [31:0] rdata);
    logic        io;
    logic [1:0]  r;
    logic [31:0] exp_rd;
    logic        rx_push;
    @(negedge clk);
    bus.adr = a; bus.writedata = wd; bus.memwrite = we; bus.req = rq;
    bus.tx_ready = txr; bus.rx_valid = rxv; bus.rx_data = rxd;
    #1;
    io = (a[31:28] == 4'hF);
    r  = a[3:2];
    check("bram_wea", {31'h0, bus.bram_wea}, {31'h0, we & ~io});
    exp_rd = 32'h0;
    if (io && r == 2'd1 && rxq.size() > 0) exp_rd = {24'h0, rxq[0]};
    if (io && r == 2'd2)                   exp_rd = model_status();
    rx_push = rxv && (rxq.size() < DEPTH);
    if (txq.size() > 0 && txr) void'(txq.pop_front());
    if (io && rq && we && r == 2'd0) begin
      if (txq.size() < DEPTH) txq.push_back(wd[7:0]);
      else                    ovf = 1'b1;
    end
    if (io && rq && we && r == 2'd2) ovf = 1'b0;
    if (io && rq && !we && r == 2'd1 && rxq.size() > 0) void'(rxq.pop_front());
    if (rx_push) rxq.push_back(rxd);
    @(posedge clk);
    #1;
    rdata = bus.readdata;
    if (io && !we) check("io_read", rdata, exp_rd);
    check("tx_valid", {31'h0, bus.tx_valid}, {31'h0, txq.size() > 0});
    if (txq.size() > 0) check("tx_data", {24'h0, bus.tx_data}, {24'h0, txq[0]});
    check("rx_ready", {31'h0, bus.rx_ready}, {31'h0, rxq.size() < DEPTH});
  endtask

  initial begin
    bus.adr = '0; bus.writedata = '0; bus.memwrite = 1'b0; bus.req = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    cycle(STA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("rst_status", rd, 32'h0000_0006);

    // BRAM write then read-back
    cycle(32'h100, 32'hDEAD_BEEF, 1, 1, 0, 0, 8'h00, rd);
    cycle(32'h100, 32'h0, 0, 1, 0, 0, 8'h00, rd);
    check("bram_read", rd, 32'hDEAD_BEEF);
    cycle(STA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("bram_no_mmio", rd, 32'h0000_0006);

    // TX: two bytes queued while transmitter stalls, then drained in order
    cycle(TXA, 32'h41, 1, 1, 0, 0, 8'h00, rd);
    cycle(TXA, 32'h42, 1, 1, 0, 0, 8'h00, rd);
    check("tx_head", {24'h0, bus.tx_data}, 32'h41);
    cycle(STA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("tx_count", {24'h0, rd[23:16]}, 32'h2);
    cycle(TXA, 0, 0, 1, 1, 0, 8'h00, rd);
    check("txdata_read_zero", rd, 32'h0);
    repeat (2) cycle(RSV, 0, 0, 0, 1, 0, 8'h00, rd);
    check("tx_drained", {31'h0, bus.tx_valid}, 32'h0);

    // TX overflow: 17 writes, 16 kept, sticky flag cleared by STATUS write
    for (int i = 0; i < 17; i++) cycle(TXA, 32'h60 + i, 1, 1, 0, 0, 8'h00, rd);
    cycle(STA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("tx_ovf_status", rd, 32'h0010_0008);
    cycle(STA, 32'hFFFF_FFFF, 1, 1, 0, 0, 8'h00, rd);
    cycle(STA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("ovf_cleared", rd, 32'h0010_0000);
    cycle(TXA, 32'h77, 1, 1, 1, 0, 8'h00, rd);
    repeat (17) cycle(RSV, 0, 0, 0, 1, 0, 8'h00, rd);

    // RX: two bytes in, three reads
    cycle(RSV, 0, 0, 0, 0, 1, 8'h5A, rd);
    cycle(RSV, 0, 0, 0, 0, 1, 8'hA5, rd);
    cycle(RXA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("rx_first", rd, 32'h5A);
    cycle(RXA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("rx_second", rd, 32'hA5);
    cycle(RXA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("rx_empty_read", rd, 32'h0);
    cycle(STA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("rx_nonempty_bit", {31'h0, rd[0]}, 32'h0);

    // RX full: backpressure holds the 17th byte until a read frees a slot
    for (int i = 0; i < 16; i++) cycle(RSV, 0, 0, 0, 0, 1, 8'h80 + 8'(i), rd);
    check("rx_full_ready", {31'h0, bus.rx_ready}, 32'h0);
    repeat (2) cycle(RSV, 0, 0, 0, 0, 1, 8'h90, rd);
    cycle(RXA, 0, 0, 1, 0, 1, 8'h90, rd);
    check("rx_full_read", rd, 32'h80);
    cycle(RSV, 0, 0, 0, 0, 1, 8'h90, rd);
    for (int i = 0; i < 16; i++) cycle(RXA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("rx_held_byte", rd, 32'h90);

    // Asynchronous reset with both FIFOs partly filled
    for (int i = 0; i < 3; i++) cycle(TXA, 32'hC0 + i, 1, 1, 0, 1, 8'hD0 + 8'(i), rd);
    #2;
    bus.req = 1'b0; bus.memwrite = 1'b0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check("async_rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("async_rst_rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    txq.delete(); rxq.delete(); ovf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cycle(STA, 0, 0, 1, 0, 0, 8'h00, rd);
    check("post_rst_status", rd, 32'h0000_0006);

    // Randomized MMIO traffic against the queue model
    for (int k = 0; k < 600; k++) begin
      logic [1:0]  sel;
      logic        we, rq, txr, rxv;
      sel = 2'($urandom_range(0, 3));
      we  = (sel == 2'd0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      rq  = ($urandom_range(0, 3) != 0);
      txr = (k % 200 < 100) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
      rxv = (k % 200 < 100) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      cycle(TXA | {28'h0, sel, 2'b00}, $urandom, we, rq, txr, rxv, 8'($urandom), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
